// File: rtl/reg_write_queue_pkg.sv
// Shared constants and the request entry type for the register-file write queue.
package reg_write_queue_pkg;

  localparam int DATA_W     = 6;
  localparam int NREGS_DEF  = 8;
  localparam int ADDR_W_DEF = 3;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W-1:0]     data;
  } req_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// Synchronous FIFO holding pending register writes; pointers wrap modulo DEPTH.
module wq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 9,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reg_write_queue.sv
// Register-file write front end: queues (addr,data) requests and retires one per cycle
// as a one-hot select plus write strobe; also keeps a sticky error flag.
module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DEPTH  = 4,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  input  logic              hold,
  output logic [NREGS-1:0]  chosen,
  output logic              w_en,
  output logic [DATA_W-1:0] w_data,
  input  logic [NREGS-1:0]  reg_err,
  output logic              err,
  output logic [LVL_W-1:0]  level
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              legal;

  logic              w_en_p1;
  logic [NREGS-1:0]  chosen_p1;
  logic [DATA_W-1:0] w_data_p1;
  logic              err_p1;

  function automatic logic [NREGS-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[i] = (a == ADDR_W'(i));
    return v;
  endfunction

  // Ready is not pop-aware: a full queue refuses even when it drains this cycle.
  assign req_ready = rst & ~full;
  assign push      = req_valid & req_ready;
  assign pop       = ~empty & ~hold;
  assign {head_addr, head_data} = head;

  wq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_addr, req_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  generate
    if (NREGS < (1 << ADDR_W)) begin : g_addr_chk
      assign legal = ({1'b0, head_addr} < (ADDR_W + 1)'(NREGS));
    end else begin : g_addr_full
      assign legal = 1'b1;
    end
  endgenerate

  // Stage p1: retire register, one pulse per legal pop; illegal entries raise err instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_en_p1   <= 1'b0;
      chosen_p1 <= '0;
      w_data_p1 <= '0;
      err_p1    <= 1'b0;
    end else begin
      w_en_p1   <= pop & legal;
      chosen_p1 <= (pop & legal) ? decode(head_addr) : '0;
      if (pop & legal) w_data_p1 <= head_data;
      if ((|reg_err) | (pop & ~legal)) err_p1 <= 1'b1;
    end
  end

  assign w_en   = w_en_p1;
  assign chosen = chosen_p1;
  assign w_data = w_data_p1;
  assign err    = err_p1;

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed plus randomized bench for reg_write_queue (NREGS=8 and NREGS=6 instances).
module tb_reg_write_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] req_addr = '0;
  logic [5:0] req_data = '0;
  logic [7:0] reg_err = '0;

  logic       rdy8, wen8, err8;
  logic [7:0] ch8;
  logic [5:0] wd8;
  logic [2:0] lvl8;
  logic       rdy6, wen6, err6;
  logic [5:0] ch6;
  logic [5:0] wd6;
  logic [2:0] lvl6;

  int    n_chk = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference model: a queue of {addr,data} plus expected registered outputs per instance.
  logic [8:0] q [$];
  logic       ewen [2];
  logic [7:0] ech  [2];
  logic [5:0] ewd  [2];
  logic       eerr [2];

  always #5 clk = ~clk;

  reg_write_queue #(.NREGS(8), .ADDR_W(3), .DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy8), .hold(hold), .chosen(ch8), .w_en(wen8), .w_data(wd8),
    .reg_err(reg_err), .err(err8), .level(lvl8)
  );

  reg_write_queue #(.NREGS(6), .ADDR_W(3), .DEPTH(4)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy6), .hold(hold), .chosen(ch6), .w_en(wen6), .w_data(wd6),
    .reg_err(reg_err[5:0]), .err(err6), .level(lvl6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_rdy;
    exp_rdy = rst && (q.size() != 4);
    chk("ready8", 32'(rdy8), 32'(exp_rdy));
    chk("level8", 32'(lvl8), 32'(q.size()));
    chk("w_en8",  32'(wen8), 32'(ewen[0]));
    chk("chosen8", 32'(ch8), 32'(ech[0]));
    chk("w_data8", 32'(wd8), 32'(ewd[0]));
    chk("err8",   32'(err8), 32'(eerr[0]));
    chk("ready6", 32'(rdy6), 32'(exp_rdy));
    chk("level6", 32'(lvl6), 32'(q.size()));
    chk("w_en6",  32'(wen6), 32'(ewen[1]));
    chk("chosen6", 32'(ch6), 32'(ech[1]));
    chk("w_data6", 32'(wd6), 32'(ewd[1]));
    chk("err6",   32'(err6), 32'(eerr[1]));
  endtask

  // Advance the model with the inputs present before the edge, then clock and compare.
  task automatic tick();
    logic       pop, push;
    logic [8:0] e;
    logic [7:0] re;
    int         n;
    e = '0;
    if (!rst) begin
      q.delete();
      for (int i = 0; i < 2; i++) begin
        ewen[i] = 1'b0; ech[i] = '0; ewd[i] = '0; eerr[i] = 1'b0;
      end
    end else begin
      pop  = (q.size() != 0) && !hold;
      push = req_valid && (q.size() != 4);
      if (pop) e = q.pop_front();
      if (push) q.push_back({req_addr, req_data});
      for (int i = 0; i < 2; i++) begin
        n  = (i == 0) ? 8 : 6;
        re = (i == 0) ? reg_err : {2'b00, reg_err[5:0]};
        ewen[i] = 1'b0;
        ech[i]  = '0;
        if (pop) begin
          if (int'(e[8:6]) < n) begin
            ewen[i] = 1'b1;
            ech[i]  = 8'd1 << e[8:6];
            ewd[i]  = e[5:0];
          end else begin
            eerr[i] = 1'b1;
          end
        end
        if (re != 8'h00) eerr[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset held two cycles with a request offered: nothing may be accepted.
    phase = "reset";
    rst = 1'b0; req_valid = 1'b1; req_addr = 3'd3; req_data = 6'h11;
    tick(); tick();
    chk("ready_in_reset", 32'(rdy8), 32'd0);
    rst = 1'b1; req_valid = 1'b0;
    tick();
    chk("ready_after_release", 32'(rdy8), 32'd1);
    chk("level_after_release", 32'(lvl8), 32'd0);

    phase = "single";
    req_valid = 1'b1; req_addr = 3'd3; req_data = 6'h2A;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wen", 32'(wen8), 32'd1);
    chk("chosen", 32'(ch8), 32'h08);
    chk("wdata", 32'(wd8), 32'h2A);
    tick();
    chk("wen_off", 32'(wen8), 32'd0);
    chk("chosen_off", 32'(ch8), 32'd0);
    chk("wdata_kept", 32'(wd8), 32'h2A);

    phase = "fill";
    hold = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr = 3'(i); req_data = 6'(16 + i);
      tick();
    end
    chk("level_full", 32'(lvl8), 32'd4);
    chk("ready_full", 32'(rdy8), 32'd0);
    req_valid = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_wen", 32'(wen8), 32'd1);
      chk("drain_order", 32'(wd8), 32'(16 + i));
    end
    tick();
    chk("drain_done", 32'(wen8), 32'd0);
    chk("drain_ready", 32'(rdy8), 32'd1);

    phase = "same_reg";
    req_valid = 1'b1; req_addr = 3'd2; req_data = 6'h01;
    tick();
    req_data = 6'h3F;
    tick();
    req_valid = 1'b0;
    chk("first_chosen", 32'(ch8), 32'h04);
    chk("first_data", 32'(wd8), 32'h01);
    tick();
    chk("second_chosen", 32'(ch8), 32'h04);
    chk("second_data", 32'(wd8), 32'h3F);
    tick();

    phase = "illegal";
    req_valid = 1'b1; req_addr = 3'd7; req_data = 6'h15;
    tick();
    req_valid = 1'b0;
    tick();
    chk("ill_wen6", 32'(wen6), 32'd0);
    chk("ill_chosen6", 32'(ch6), 32'd0);
    chk("ill_err6", 32'(err6), 32'd1);
    chk("ill_err8_clear", 32'(err8), 32'd0);
    chk("ill_chosen8", 32'(ch8), 32'h80);
    tick();
    chk("ill_err6_sticky", 32'(err6), 32'd1);
    req_valid = 1'b1; req_addr = 3'd4; req_data = 6'h2C;
    tick();
    req_valid = 1'b0;
    tick();
    chk("legal_after_wen6", 32'(wen6), 32'd1);
    chk("legal_after_chosen6", 32'(ch6), 32'h10);

    phase = "reg_err";
    reg_err = 8'h02;
    tick();
    reg_err = 8'h00;
    chk("err8_set", 32'(err8), 32'd1);
    tick();
    chk("err8_sticky", 32'(err8), 32'd1);

    phase = "mid_reset";
    hold = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 3'(i + 1); req_data = 6'(40 + i);
      tick();
    end
    req_valid = 1'b0; hold = 1'b0;
    tick();
    chk("pulse_before_reset", 32'(wen8), 32'd1);
    rst = 1'b0;
    tick();
    chk("wen_reset", 32'(wen8), 32'd0);
    chk("level_reset", 32'(lvl8), 32'd0);
    chk("err_reset", 32'(err8), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_write_after_reset", 32'(wen8), 32'd0);
    end

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      hold      = ($urandom_range(0, 9) < 3);
      req_addr  = 3'($urandom_range(0, 7));
      req_data  = 6'($urandom);
      reg_err   = ($urandom_range(0, 199) == 0) ? 8'h01 : 8'h00;
      rst       = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
